// File: rtl/data_bus_arbiter_pkg.sv
// data_bus_arbiter_pkg: shared bus arbiter state encoding and default hold limits
package data_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int MAX_HOLD_DEF = 8;
    localparam int LOCK_MAX_DEF = 32;

endpackage

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: two-master round-robin bus arbiter with hold limit and m1 lock
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wenable,
    output logic        m0_gnt,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wenable,
    output logic        m1_gnt,
    output logic [31:0] m1_rdata,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wenable,
    input  logic [31:0] bus_rdata,
    output logic        owner
);

    localparam int HW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] LOCK_LIM = HW'(LOCK_MAX - 1);

    arb_state_t    state;
    arb_state_t    nxt;
    logic [HW-1:0] hold;
    logic [HW-1:0] lim1;

    // next owner: round-robin from idle, hand over on release or when the hold limit is hit
    always_comb begin
        lim1 = m1_lock ? LOCK_LIM : HOLD_LIM;
        nxt  = (state == OWN0) ? (!m0_req ? (m1_req ? OWN1 : IDLE) : (m1_req && hold >= HOLD_LIM) ? OWN1 : OWN0)
             : (state == OWN1) ? (!m1_req ? (m0_req ? OWN0 : IDLE) : (m0_req && hold >= lim1) ? OWN0 : OWN1)
             : (m0_req && m1_req) ? (owner ? OWN0 : OWN1)
             : m0_req ? OWN0 : m1_req ? OWN1 : IDLE;
    end

    // state, saturating hold counter, last owner and registered grants
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            hold   <= '0;
            owner  <= 1'b1;
            m0_gnt <= 1'b0;
            m1_gnt <= 1'b0;
        end else begin
            state  <= nxt;
            hold   <= (nxt != state) ? '0 : (state != IDLE && hold != LOCK_LIM) ? hold + 1'b1 : hold;
            owner  <= (nxt == OWN0) ? 1'b0 : (nxt == OWN1) ? 1'b1 : owner;
            m0_gnt <= (nxt == OWN0);
            m1_gnt <= (nxt == OWN1);
        end
    end

    // bus mux follows the granted master; writes only pass while its request is up
    always_comb begin
        bus_addr    = m0_gnt ? m0_addr : m1_gnt ? m1_addr : 32'd0;
        bus_wdata   = m0_gnt ? m0_wdata : m1_gnt ? m1_wdata : 32'd0;
        bus_wenable = (m0_gnt && m0_req) ? m0_wenable : (m1_gnt && m1_req) ? m1_wenable : 4'b0000;
        m0_rdata    = bus_rdata;
        m1_rdata    = bus_rdata;
    end

endmodule
